// File: rtl/block_writer.sv
`default_nettype none
// ============================================================================
// Module   : block_writer
// Brief    : Reads a 64-sample IDCT block, clips to 8 bits, packs pixel pairs
//            and writes them to the Y/U/V plane in SRAM at the block position.
// Revision : 1.0
// ============================================================================
module block_writer #(
    parameter logic [17:0] Y_OFFSET = 18'd0,
    parameter logic [17:0] U_OFFSET = 18'd38400,
    parameter logic [17:0] V_OFFSET = 18'd57600
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        start,
    input  logic [1:0]  plane,
    input  logic [4:0]  blockRow,
    input  logic [5:0]  blockCol,
    output logic [5:0]  ramAddr,
    input  logic [31:0] ramData,
    output logic [17:0] sramAddress,
    output logic [15:0] sramWriteData,
    output logic        sramWe_n,
    output logic        busy,
    output logic        done
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    localparam logic [6:0] C_LAST_CNT   = 7'd65;
    localparam logic [6:0] C_FIRST_SMPL = 7'd1;
    localparam logic [6:0] C_LAST_SMPL  = 7'd64;
    localparam logic [5:0] C_LAST_ADDR  = 6'd63;

    logic [1:0]  r_state;
    logic [1:0]  w_state_nxt;
    logic [6:0]  r_cnt;
    logic [4:0]  r_pair;
    logic [1:0]  r_plane;
    logic [4:0]  r_row;
    logic [5:0]  r_col;
    logic [7:0]  r_held;

    logic        w_accept;
    logic        w_sample_live;
    logic [7:0]  w_clip;
    logic        w_is_y;
    logic [17:0] w_offset;
    logic [17:0] w_row_term;
    logic [17:0] w_line_term;
    logic [17:0] w_col_term;
    logic [17:0] w_pair_addr;

    logic [5:0]  w_ram_addr_nxt;
    logic        w_we_n_nxt;
    logic [17:0] w_addr_nxt;
    logic [15:0] w_data_nxt;
    logic [7:0]  w_held_nxt;
    logic [6:0]  w_cnt_nxt;
    logic [4:0]  w_pair_nxt;
    logic        w_busy_nxt;
    logic        w_done_nxt;

    // The done cycle is not busy, so a start there is accepted straight away.
    assign w_accept      = start && ((r_state == S_IDLE) || (r_state == S_DONE));
    // r_cnt is the number of edges since the accepting edge; sample k lands when r_cnt == k+1.
    assign w_sample_live = (r_cnt >= C_FIRST_SMPL) && (r_cnt <= C_LAST_SMPL);

    always_comb begin : p_clip
        if (ramData[31]) begin
            w_clip = 8'd0;
        end else if (|ramData[30:8]) begin
            w_clip = 8'hFF;
        end else begin
            w_clip = ramData[7:0];
        end
    end

    assign w_is_y   = (r_plane == 2'd0);
    assign w_offset = (r_plane == 2'd0) ? Y_OFFSET :
                      (r_plane == 2'd1) ? U_OFFSET : V_OFFSET;

    // Row of blocks: 1280 = 1024+256 words (Y), 640 = 512+128 words (U/V).
    assign w_row_term  = w_is_y ? ({3'b0, r_row, 10'b0} + {5'b0, r_row, 8'b0})
                                : ({4'b0, r_row, 9'b0}  + {6'b0, r_row, 7'b0});
    // Line within the block: 160 = 128+32 (Y), 80 = 64+16 (U/V).
    assign w_line_term = w_is_y ? ({8'b0, r_pair[4:2], 7'b0} + {10'b0, r_pair[4:2], 5'b0})
                                : ({9'b0, r_pair[4:2], 6'b0} + {11'b0, r_pair[4:2], 4'b0});
    assign w_col_term  = {10'b0, r_col, 2'b0};
    assign w_pair_addr = w_offset + w_row_term + w_line_term + w_col_term
                       + {16'b0, r_pair[1:0]};

    always_ff @(posedge clock) begin : p_state_reg
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin : p_next_state
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (start) w_state_nxt = S_RUN;
            S_RUN:   if (r_cnt == C_LAST_CNT) w_state_nxt = S_DONE;
            S_DONE:  w_state_nxt = start ? S_RUN : S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_comb begin : p_outputs
        w_ram_addr_nxt = ramAddr;
        w_we_n_nxt     = 1'b1;
        w_addr_nxt     = sramAddress;
        w_data_nxt     = sramWriteData;
        w_held_nxt     = r_held;
        w_cnt_nxt      = r_cnt;
        w_pair_nxt     = r_pair;
        w_busy_nxt     = (w_state_nxt == S_RUN);
        w_done_nxt     = (w_state_nxt == S_DONE);
        if (w_accept) begin
            w_ram_addr_nxt = 6'd0;
            w_cnt_nxt      = 7'd0;
            w_pair_nxt     = 5'd0;
        end else if (r_state == S_RUN) begin
            w_cnt_nxt = r_cnt + 7'd1;
            if (ramAddr != C_LAST_ADDR) begin
                w_ram_addr_nxt = ramAddr + 6'd1;
            end
            if (w_sample_live) begin
                if (r_cnt[0]) begin
                    w_held_nxt = w_clip;
                end else begin
                    w_we_n_nxt = 1'b0;
                    w_addr_nxt = w_pair_addr;
                    w_data_nxt = {r_held, w_clip};
                    w_pair_nxt = r_pair + 5'd1;
                end
            end
        end
    end

    always_ff @(posedge clock) begin : p_datapath
        if (reset) begin
            ramAddr       <= 6'd0;
            sramAddress   <= 18'd0;
            sramWriteData <= 16'd0;
            sramWe_n      <= 1'b1;
            busy          <= 1'b0;
            done          <= 1'b0;
            r_held        <= 8'd0;
            r_cnt         <= 7'd0;
            r_pair        <= 5'd0;
            r_plane       <= 2'd0;
            r_row         <= 5'd0;
            r_col         <= 6'd0;
        end else begin
            ramAddr       <= w_ram_addr_nxt;
            sramAddress   <= w_addr_nxt;
            sramWriteData <= w_data_nxt;
            sramWe_n      <= w_we_n_nxt;
            busy          <= w_busy_nxt;
            done          <= w_done_nxt;
            r_held        <= w_held_nxt;
            r_cnt         <= w_cnt_nxt;
            r_pair        <= w_pair_nxt;
            if (w_accept) begin
                r_plane <= plane;
                r_row   <= blockRow;
                r_col   <= blockCol;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_block_writer.sv
`default_nettype none
// ============================================================================
// Module   : tb_block_writer
// Brief    : Randomised scoreboard bench for block_writer with a sync RAM model.
// Revision : 1.0
// ============================================================================
module tb_block_writer;

    logic        clock;
    logic        reset;
    logic        start;
    logic [1:0]  plane;
    logic [4:0]  blockRow;
    logic [5:0]  blockCol;
    logic [5:0]  ramAddr;
    logic [31:0] ramData;
    logic [17:0] sramAddress;
    logic [15:0] sramWriteData;
    logic        sramWe_n;
    logic        busy;
    logic        done;

    typedef struct {
        int addr;
        int data;
        int cyc;
    } wr_t;

    wr_t exp_q[$];
    int  done_q[$];
    int  mem [64];
    int  cyc = 0;
    int  checks = 0;
    int  failures = 0;

    block_writer dut (
        .clock         (clock),
        .reset         (reset),
        .start         (start),
        .plane         (plane),
        .blockRow      (blockRow),
        .blockCol      (blockCol),
        .ramAddr       (ramAddr),
        .ramData       (ramData),
        .sramAddress   (sramAddress),
        .sramWriteData (sramWriteData),
        .sramWe_n      (sramWe_n),
        .busy          (busy),
        .done          (done)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    always @(posedge clock) cyc <= cyc + 1;
    always @(posedge clock) ramData <= mem[ramAddr];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic int clip8(input int v);
        if (v < 0) return 0;
        if (v > 255) return 255;
        return v;
    endfunction

    // Reference: address = plane base + (pixel line)*stride + column of the pair.
    function automatic void push_expected(input int pl, input int row, input int col, input int e0);
        int  off;
        int  s;
        wr_t w;
        off = (pl == 0) ? 0 : (pl == 1) ? 38400 : 57600;
        s   = (pl == 0) ? 160 : 80;
        for (int p = 0; p < 32; p++) begin
            w.addr = (off + (row * 8 + p / 4) * s + col * 4 + p % 4) % 262144;
            w.data = clip8(mem[2*p]) * 256 + clip8(mem[2*p+1]);
            w.cyc  = e0 + 2 * p + 3;
            exp_q.push_back(w);
        end
        done_q.push_back(e0 + 66);
    endfunction

    function automatic void fill_mem(input int mode);
        for (int k = 0; k < 64; k++) begin
            if (mode == 0) begin
                mem[k] = k;
            end else if ($urandom_range(0, 3) == 0) begin
                mem[k] = int'($urandom);
            end else begin
                mem[k] = int'($urandom_range(0, 700)) - 200;
            end
        end
        if (mode == 2) begin
            mem[0] = -5;  mem[1] = 300; mem[2] = 255;
            mem[3] = 0;   mem[4] = 128; mem[5] = 127;
        end
    endfunction

    always @(negedge clock) begin
        wr_t w;
        int  dc;
        if (sramWe_n === 1'b0) begin
            if (exp_q.size() == 0) begin
                check("unexpected_write", 32'd1, 32'd0);
            end else begin
                w = exp_q.pop_front();
                check("wr_addr", 32'(sramAddress), w.addr);
                check("wr_data", 32'(sramWriteData), w.data);
                check("wr_cycle", cyc, w.cyc);
            end
        end
        if (done === 1'b1) begin
            if (done_q.size() == 0) begin
                check("unexpected_done", 32'd1, 32'd0);
            end else begin
                dc = done_q.pop_front();
                check("done_cycle", cyc, dc);
                check("busy_in_done", 32'(busy), 32'd0);
            end
        end
    end

    task automatic accept_block(input int pl, input int row, input int col, output int e0);
        start    = 1'b1;
        plane    = 2'(pl);
        blockRow = 5'(row);
        blockCol = 6'(col);
        @(posedge clock); #1;
        e0 = cyc;
        push_expected(pl, row, col, e0);
        start    = 1'b0;
        plane    = 2'($urandom);
        blockRow = 5'($urandom);
        blockCol = 6'($urandom);
        check("busy_after_start", 32'(busy), 32'd1);
        check("ramaddr_after_start", 32'(ramAddr), 32'd0);
    endtask

    task automatic finish_block();
        repeat (66) @(posedge clock);
        #1;
        @(posedge clock); #1;
        check("writes_outstanding", exp_q.size(), 32'd0);
        check("done_outstanding", done_q.size(), 32'd0);
    endtask

    task automatic run_block(input int pl, input int row, input int col);
        int e0;
        accept_block(pl, row, col, e0);
        finish_block();
    endtask

    task automatic run_glitch_b2b();
        int e0;
        accept_block(0, 5, 17, e0);
        repeat (9) @(posedge clock); #1;
        start = 1'b1; plane = 2'd1; blockRow = 5'd1; blockCol = 6'd1;
        @(posedge clock); #1;
        start = 1'b0;
        repeat (29) @(posedge clock); #1;
        start = 1'b1; plane = 2'd2; blockRow = 5'd2; blockCol = 6'd2;
        @(posedge clock); #1;
        start = 1'b0;
        repeat (26) @(posedge clock); #1;
        check("done_pulse_e66", 32'(done), 32'd1);
        check("busy_low_e66", 32'(busy), 32'd0);
        accept_block(1, 13, 9, e0);
        finish_block();
    endtask

    task automatic run_abort();
        int e0;
        accept_block(2, 7, 3, e0);
        repeat (19) @(posedge clock); #1;
        reset = 1'b1;
        @(posedge clock); #1;
        exp_q.delete();
        done_q.delete();
        reset = 1'b0;
        check("abort_we_n", 32'(sramWe_n), 32'd1);
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_done", 32'(done), 32'd0);
        check("abort_ramaddr", 32'(ramAddr), 32'd0);
        repeat (80) @(posedge clock); #1;
        check("abort_idle_busy", 32'(busy), 32'd0);
        fill_mem(1);
        run_block(2, 7, 3);
    endtask

    initial begin
        int pl;
        reset    = 1'b1;
        start    = 1'b0;
        plane    = 2'd0;
        blockRow = 5'd0;
        blockCol = 6'd0;
        for (int k = 0; k < 64; k++) mem[k] = 0;
        repeat (3) @(posedge clock); #1;
        check("rst_ramaddr", 32'(ramAddr), 32'd0);
        check("rst_sramaddr", 32'(sramAddress), 32'd0);
        check("rst_wdata", 32'(sramWriteData), 32'd0);
        check("rst_we_n", 32'(sramWe_n), 32'd1);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        reset = 1'b0;
        @(posedge clock); #1;

        fill_mem(0); run_block(0, 0, 0);
        fill_mem(1); run_block(1, 2, 5);
        fill_mem(2); run_block(0, 3, 7);
        fill_mem(1); run_block(0, 29, 39);
        fill_mem(1); run_block(2, 29, 19);
        fill_mem(1); run_block(3, 10, 4);
        fill_mem(1); run_glitch_b2b();
        run_abort();
        for (int i = 0; i < 6; i++) begin
            pl = int'($urandom_range(0, 3));
            fill_mem(1);
            run_block(pl, int'($urandom_range(0, 29)),
                      int'($urandom_range(0, (pl == 0) ? 39 : 19)));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/block_writer.md
# block_writer

Writes one decoded 8x8 pixel block back to external SRAM in packed pixel-pair form. It sits after the IDCT stage. It reads 64 signed 32-bit sample values from the compute stage's synchronous dual-port RAM, clips each to 8 bits, packs pairs into 16-bit words, and writes them to the Y, U or V output region at the block's raster position. It is the write-side counterpart of the block-fetch address generator.

## Interface
Parameters:
- Y_OFFSET, 18'd0: SRAM word address of the Y output plane.
- U_OFFSET, 18'd38400: SRAM word address of the U output plane.
- V_OFFSET, 18'd57600: SRAM word address of the V output plane.

Ports:
- clock  in  1  single clock, rising edge.
- reset  in  1  synchronous, active-high.
- start  in  1  begin a block; sampled only while busy=0.
- plane  in  2  0=Y, 1=U, 2=V; 3 is treated as V.
- blockRow  in  5  block row index, 0..29.
- blockCol  in  6  block column index, 0..39 for Y, 0..19 for U/V.
- ramAddr  out  6  read address to the sample RAM.
- ramData  in  32  signed sample; valid one cycle after ramAddr is presented.
- sramAddress  out  18  SRAM word address.
- sramWriteData  out  16  packed pixel pair.
- sramWe_n  out  1  active-low write enable.
- busy  out  1  high while a block is in progress.
- done  out  1  one-cycle pulse after the last write.

## Operation
- States: IDLE, RUN, DONE.
- IDLE -> RUN: start=1 sampled with busy=0. plane, blockRow and blockCol are latched at that edge. Input changes after that edge are ignored.
- RUN issues ramAddr 0..63, one per cycle. After 63, ramAddr holds 63.
- Each returned sample k is clipped:
  - <0 -> 0
  - >255 -> 255
  - otherwise bits [7:0]
- Even k: the clipped value is held in a register.
- Odd k: one SRAM write of {clip(k-1), clip(k)}. The even pixel goes in bits [15:8].
- Stride S: 160 words for Y, 80 for U/V.
- Pair p (0..31) is located at r = p>>2, c = p&3.
- Write address = planeOffset + blockRow*8*S + r*S + blockCol*4 + c.
  - Implement all multiplies as shift-adds: 1280 = 1024+256, 640 = 512+128, 160 = 128+32, 80 = 64+16.
  - 18-bit arithmetic, modulo 2^18; input ranges are not checked.
- After the 32nd write, the block moves to DONE for one cycle (done=1), then returns to IDLE.
- start while busy=1 is ignored; it is not queued.
- Reset at any time: next state IDLE, sramWe_n=1, busy=0, done=0. No further writes occur. A partially written block is abandoned.

## Timing
- Reset values:
  - ramAddr=0, sramAddress=0, sramWriteData=0
  - sramWe_n=1, busy=0, done=0
  - held pixel=0, state IDLE
- All outputs are registered.
- Let E0 be the edge that accepts start.
  - ramAddr=k is visible after edge E_k (k=0..63).
  - ramData for k is valid after E_{k+1} and is captured at E_{k+2}.
  - The write for pair p is visible after E_{2p+3}: sramWe_n=0 with sramAddress and sramWriteData valid together, for exactly one cycle.
  - sramWe_n=1 on all other cycles. Writes alternate low/high, so the first write is after E3 and the last after E65.
- busy=1 from after E0 through E65. After E66: busy=0, done=1 for one cycle, sramWe_n=1.
- A start asserted during the done cycle is accepted at E67. Block-to-block throughput is 67 cycles.
- Latency from start to done is 66 cycles.

## Test plan
- Y block (0,0), ramData=k:
  - 32 writes, in order: addr 0 = 0x0001, 1 = 0x0203, 3 = 0x0607, 160 = 0x0809, 1123 = 0x3E3F.
  - done=1 for exactly one cycle, after E66.
- U block row 2, col 5: first write to 39700, last to 40263. Address step pattern is +1,+1,+1,+77.
- Clipping, ramData sequence -5, 300, 255, 0, 128, 127: words 0x00FF, 0xFF00, 0x807F.
- Corner blocks:
  - Y (29,39): first 37276, last 38399.
  - V (29,19): first 76236, last 76799.
  - No address falls outside the addressed plane.
- Start pulses during busy at E10 and E40: no effect, still exactly 32 writes. A start held during the done cycle begins a new block with ramAddr=0 after E67.
- reset=1 at E20:
  - after E20: sramWe_n=1, busy=0, done=0, ramAddr=0.
  - no writes and no done until the next start.
  - the next block then completes normally with correct data.
